// File: rtl/sl3p_link_supervisor_if.sv
// Serdes-side status/control bundle for the SL3P link supervisor.
// master = serdes wrapper (drives lock/ECC status), slave = supervisor (drives serdes_rst).
interface sl3p_link_supervisor_if #(
  parameter int unsigned LANES = 4
);

  logic [LANES-1:0] word_lock;
  logic             deskew_locked;
  logic             rx_valid;
  logic [LANES-1:0] rx_fix;
  logic [LANES-1:0] rx_fail;
  logic             fifo_err;
  logic             serdes_rst;

  modport master (
    output word_lock,
    output deskew_locked,
    output rx_valid,
    output rx_fix,
    output rx_fail,
    output fifo_err,
    input  serdes_rst
  );

  modport slave (
    input  word_lock,
    input  deskew_locked,
    input  rx_valid,
    input  rx_fix,
    input  rx_fail,
    input  fifo_err,
    output serdes_rst
  );

endinterface

// File: rtl/sl3p_link_supervisor.sv
// N-lane SL3P serdes health monitor: reset sequencing, lock qualification,
// ECC/FIFO error supervision with automatic retrain, and per-lane statistics.
module sl3p_link_supervisor #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned QUAL_CYCLES  = 8,
  parameter int unsigned LOCK_TO_BITS = 10,
  parameter int unsigned WIN_BITS     = 8,
  parameter int unsigned FAIL_THRESH  = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     enable,
  input  logic                     clr_stats,
  sl3p_link_supervisor_if.slave    serdes,
  output logic                     link_up,
  output logic [2:0]               state,
  output logic [7:0]               retrain_cnt,
  output logic [LANES*CNT_W-1:0]   fix_cnt,
  output logic [LANES*CNT_W-1:0]   fail_cnt
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned QUAL_W = $clog2(QUAL_CYCLES + 1);
  localparam int unsigned POP_W  = $clog2(LANES + 1);
  localparam int unsigned ACC_W  = $clog2(FAIL_THRESH + LANES + 1);
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_UP        = 3'd3,
    ST_RETRAIN   = 3'd4
  } state_e;

  typedef logic [LANES-1:0][CNT_W-1:0] lane_cnt_t;

  state_e                  state_q,      state_d;
  logic [HOLD_W-1:0]       hold_q,       hold_d;
  logic [QUAL_W-1:0]       qual_q,       qual_d;
  logic [LOCK_TO_BITS-1:0] lock_tmr_q,   lock_tmr_d;
  logic [WIN_BITS-1:0]     win_q,        win_d;
  logic [ACC_W-1:0]        acc_q,        acc_d;
  logic [7:0]              retrain_q,    retrain_d;
  lane_cnt_t               fix_q,        fix_d;
  lane_cnt_t               fail_q,       fail_d;
  logic                    serdes_rst_q, serdes_rst_d;
  logic                    link_up_q,    link_up_d;

  logic             good;
  logic [POP_W-1:0] inc;
  logic [SUM_W-1:0] sum;
  logic             trip;
  logic [ACC_W-1:0] acc_sat;

  function automatic logic [POP_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

  // Lock quality and windowed uncorrected-error accumulation (includes this cycle).
  always_comb begin
    good    = (&serdes.word_lock) & serdes.deskew_locked;
    inc     = serdes.rx_valid ? popcount(serdes.rx_fail) : '0;
    sum     = SUM_W'(acc_q) + SUM_W'(inc);
    trip    = (sum >= SUM_W'(FAIL_THRESH));
    acc_sat = sum[SUM_W-1] ? '1 : sum[ACC_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    qual_d     = qual_q;
    lock_tmr_d = lock_tmr_q;
    win_d      = win_q;
    acc_d      = acc_q;
    retrain_d  = retrain_q;
    fix_d      = fix_q;
    fail_d     = fail_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RESET;
      end
      ST_RESET: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) state_d = ST_WAIT_LOCK;
        else                                    hold_d  = hold_q + HOLD_W'(1);
      end
      ST_WAIT_LOCK: begin
        qual_d     = good ? (qual_q + QUAL_W'(1)) : '0;
        lock_tmr_d = lock_tmr_q + LOCK_TO_BITS'(1);
        // Qualification beats a coincident timeout.
        if (good && (qual_q == QUAL_W'(QUAL_CYCLES - 1))) state_d = ST_UP;
        else if (&lock_tmr_q)                            state_d = ST_RETRAIN;
      end
      ST_UP: begin
        win_d = win_q + WIN_BITS'(1);
        acc_d = (&win_q) ? '0 : acc_sat;
        if (!good || serdes.fifo_err || trip) state_d = ST_RETRAIN;
      end
      ST_RETRAIN: begin
        state_d = ST_RESET;
        if (retrain_q != 8'hFF) retrain_d = retrain_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) state_d = ST_IDLE;

    // Per-state timers and the error window start fresh on every state change.
    if (state_d != state_q) begin
      hold_d     = '0;
      qual_d     = '0;
      lock_tmr_d = '0;
      win_d      = '0;
      acc_d      = '0;
    end

    if ((state_q == ST_UP) && serdes.rx_valid) begin
      for (int i = 0; i < LANES; i++) begin
        if (serdes.rx_fix[i]  && (fix_q[i]  != '1)) fix_d[i]  = fix_q[i]  + CNT_W'(1);
        if (serdes.rx_fail[i] && (fail_q[i] != '1)) fail_d[i] = fail_q[i] + CNT_W'(1);
      end
    end

    if (clr_stats) begin
      fix_d     = '0;
      fail_d    = '0;
      retrain_d = '0;
    end

    serdes_rst_d = (state_d != ST_WAIT_LOCK) && (state_d != ST_UP);
    link_up_d    = (state_d == ST_UP);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      qual_q       <= '0;
      lock_tmr_q   <= '0;
      win_q        <= '0;
      acc_q        <= '0;
      retrain_q    <= '0;
      fix_q        <= '0;
      fail_q       <= '0;
      serdes_rst_q <= 1'b1;
      link_up_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      qual_q       <= qual_d;
      lock_tmr_q   <= lock_tmr_d;
      win_q        <= win_d;
      acc_q        <= acc_d;
      retrain_q    <= retrain_d;
      fix_q        <= fix_d;
      fail_q       <= fail_d;
      serdes_rst_q <= serdes_rst_d;
      link_up_q    <= link_up_d;
    end
  end

  assign serdes.serdes_rst = serdes_rst_q;
  assign link_up           = link_up_q;
  assign state             = state_q;
  assign retrain_cnt       = retrain_q;
  assign fix_cnt           = fix_q;
  assign fail_cnt          = fail_q;

endmodule

// File: tb/tb_sl3p_link_supervisor.sv
// Scoreboard bench for sl3p_link_supervisor: a cycle-level reference model pushes
// expected outputs at each negedge; a monitor pops and compares after each posedge.
module tb_sl3p_link_supervisor;

  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned HOLD  = 16;
  localparam int unsigned QUAL  = 8;
  localparam int unsigned LTB   = 6;
  localparam int unsigned WB    = 8;
  localparam int unsigned THR   = 4;
  localparam int CMAX      = (1 << CNT_W) - 1;
  localparam int LOCK_TO   = 1 << LTB;
  localparam int WIN_LEN   = 1 << WB;

  localparam int M_IDLE = 0, M_RESET = 1, M_WAIT = 2, M_UP = 3, M_RETRAIN = 4;

  typedef struct packed {
    logic [2:0]             st;
    logic                   srst;
    logic                   lup;
    logic [7:0]             rc;
    logic [LANES*CNT_W-1:0] fix;
    logic [LANES*CNT_W-1:0] fail;
  } obs_t;

  logic clk = 1'b0;
  logic arst;
  logic enable;
  logic clr_stats;
  logic                   link_up;
  logic [2:0]             state;
  logic [7:0]             retrain_cnt;
  logic [LANES*CNT_W-1:0] fix_cnt;
  logic [LANES*CNT_W-1:0] fail_cnt;

  sl3p_link_supervisor_if #(.LANES(LANES)) sif ();

  sl3p_link_supervisor #(
    .LANES(LANES), .CNT_W(CNT_W), .HOLD_CYCLES(HOLD), .QUAL_CYCLES(QUAL),
    .LOCK_TO_BITS(LTB), .WIN_BITS(WB), .FAIL_THRESH(THR)
  ) dut (
    .clk(clk), .arst(arst), .enable(enable), .clr_stats(clr_stats),
    .serdes(sif), .link_up(link_up), .state(state), .retrain_cnt(retrain_cnt),
    .fix_cnt(fix_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  obs_t sb[$];
  bit model_on = 0;

  // Reference model state: mode and time spent in it, plus plain integer statistics.
  int m_mode, m_cycles, m_run, m_win_pos, m_win_fails, m_retrains;
  int m_fix[LANES];
  int m_fail[LANES];

  task automatic model_reset();
    m_mode = M_IDLE; m_cycles = 0; m_run = 0; m_win_pos = 0; m_win_fails = 0; m_retrains = 0;
    for (int i = 0; i < LANES; i++) begin m_fix[i] = 0; m_fail[i] = 0; end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_step(output obs_t e);
    int  nxt, fails, total;
    bit  good;
    good = (sif.word_lock == {LANES{1'b1}}) && (sif.deskew_locked == 1'b1);
    nxt  = m_mode;
    if (clr_stats) begin
      for (int i = 0; i < LANES; i++) begin m_fix[i] = 0; m_fail[i] = 0; end
      m_retrains = 0;
    end else begin
      if (m_mode == M_UP && sif.rx_valid)
        for (int i = 0; i < LANES; i++) begin
          if (sif.rx_fix[i])  m_fix[i]  = sat_inc(m_fix[i], CMAX);
          if (sif.rx_fail[i]) m_fail[i] = sat_inc(m_fail[i], CMAX);
        end
      if (m_mode == M_RETRAIN) m_retrains = sat_inc(m_retrains, 255);
    end
    case (m_mode)
      M_IDLE:  if (enable) nxt = M_RESET;
      M_RESET: if (m_cycles + 1 == HOLD) nxt = M_WAIT;
      M_WAIT: begin
        m_run = good ? m_run + 1 : 0;
        if (m_run >= QUAL) nxt = M_UP;
        else if (m_cycles + 1 == LOCK_TO) nxt = M_RETRAIN;
      end
      M_UP: begin
        fails = 0;
        if (sif.rx_valid) for (int i = 0; i < LANES; i++) fails += int'(sif.rx_fail[i]);
        total = m_win_fails + fails;
        if (!good || sif.fifo_err || total >= THR) nxt = M_RETRAIN;
        if (m_win_pos == WIN_LEN - 1) begin m_win_pos = 0; m_win_fails = 0; end
        else begin m_win_pos++; m_win_fails = total; end
      end
      default: nxt = M_RESET;
    endcase
    if (!enable) nxt = M_IDLE;
    if (nxt != m_mode) begin
      m_cycles = 0; m_run = 0; m_win_pos = 0; m_win_fails = 0;
    end else begin
      m_cycles++;
    end
    m_mode = nxt;
    e.st   = 3'(m_mode);
    e.srst = !(m_mode == M_WAIT || m_mode == M_UP);
    e.lup  = (m_mode == M_UP);
    e.rc   = 8'(m_retrains);
    for (int i = 0; i < LANES; i++) begin
      e.fix[i*CNT_W +: CNT_W]  = CNT_W'(m_fix[i]);
      e.fail[i*CNT_W +: CNT_W] = CNT_W'(m_fail[i]);
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (model_on && !arst) begin
      model_step(e);
      sb.push_back(e);
    end
  end

  always @(posedge clk) begin
    obs_t e, g;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = '{st: state, srst: sif.serdes_rst, lup: link_up, rc: retrain_cnt, fix: fix_cnt, fail: fail_cnt};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL cycle_check @%0t: got st=%0d srst=%0b up=%0b rc=%0d fix=%h fail=%h, want st=%0d srst=%0b up=%0b rc=%0d fix=%h fail=%h",
                 $time, g.st, g.srst, g.lup, g.rc, g.fix, g.fail, e.st, e.srst, e.lup, e.rc, e.fix, e.fail);
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    sif.word_lock = '1; sif.deskew_locked = 1'b1; sif.rx_valid = 1'b0;
    sif.rx_fix = '0; sif.rx_fail = '0; sif.fifo_err = 1'b0; clr_stats = 1'b0;
  endtask

  // Restart the link from IDLE and time serdes_rst release and link_up rise.
  task automatic bring_up(input string tag);
    int n, rst_low_at;
    quiet_inputs();
    enable = 1'b0;
    cyc(); cyc();
    enable = 1'b1;
    n = 0; rst_low_at = -1;
    while (n < 200 && link_up !== 1'b1) begin
      cyc(); n++;
      if (rst_low_at < 0 && sif.serdes_rst === 1'b0) rst_low_at = n;
    end
    chk({tag, "_rst_release_cycle"}, rst_low_at, HOLD + 1);
    chk({tag, "_link_up_cycle"}, n, HOLD + 1 + QUAL);
  endtask

  initial begin
    int n;
    arst = 1'b1; enable = 1'b0;
    quiet_inputs();
    model_reset();
    #3;
    chk("reset_state", state, M_IDLE);
    chk("reset_serdes_rst", sif.serdes_rst, 1);
    chk("reset_link_up", link_up, 0);
    chk("reset_retrain_cnt", retrain_cnt, 0);
    chk("reset_stats", fix_cnt | fail_cnt, 0);
    @(posedge clk); #1;
    arst = 1'b0;
    model_on = 1'b1;

    bring_up("first");

    // Randomized traffic with occasional faults; the model follows every retrain.
    for (int k = 0; k < 800; k++) begin
      sif.rx_valid      = ($urandom_range(0, 3) != 0);
      sif.rx_fix        = LANES'($urandom);
      sif.rx_fail       = ($urandom_range(0, 29) == 0) ? LANES'($urandom) : '0;
      sif.word_lock     = ($urandom_range(0, 299) == 0) ? LANES'($urandom) : '1;
      sif.deskew_locked = ($urandom_range(0, 399) != 0);
      sif.fifo_err      = ($urandom_range(0, 499) == 0);
      clr_stats         = ($urandom_range(0, 199) == 0);
      enable            = ($urandom_range(0, 499) != 0);
      cyc();
    end

    // Two double-lane failures in one window trip a retrain.
    bring_up("trip");
    clr_stats = 1'b1; cyc(); clr_stats = 1'b0;
    sif.rx_valid = 1'b1; sif.rx_fail = 4'b0011;
    cyc();
    chk("trip_after_first", state, M_UP);
    cyc();
    sif.rx_valid = 1'b0; sif.rx_fail = '0;
    chk("trip_state", state, M_RETRAIN);
    chk("trip_fail_lane0", fail_cnt[0 +: CNT_W], 2);
    chk("trip_fail_lane1", fail_cnt[CNT_W +: CNT_W], 2);
    chk("trip_fail_lane2", fail_cnt[2*CNT_W +: CNT_W], 0);

    // Failures straddling the window wrap do not accumulate across it.
    bring_up("wrap");
    for (int k = 0; k < 300; k++) begin
      sif.rx_valid = 1'b1;
      case (k)
        WIN_LEN - 6: sif.rx_fail = 4'b0011;
        WIN_LEN - 4: sif.rx_fail = 4'b0001;
        WIN_LEN + 2: sif.rx_fail = 4'b0011;
        default:     sif.rx_fail = '0;
      endcase
      cyc();
    end
    sif.rx_valid = 1'b0; sif.rx_fail = '0;
    chk("wrap_link_up", link_up, 1);
    chk("wrap_state", state, M_UP);

    // Statistic saturation and clr_stats priority.
    clr_stats = 1'b1; cyc(); clr_stats = 1'b0;
    sif.rx_valid = 1'b1; sif.rx_fix = 4'b0100;
    repeat (CMAX + 80) cyc();
    chk("fix_lane2_sat", fix_cnt[2*CNT_W +: CNT_W], CMAX);
    chk("fix_lane0_idle", fix_cnt[0 +: CNT_W], 0);
    clr_stats = 1'b1; cyc(); clr_stats = 1'b0;
    chk("fix_lane2_clr", fix_cnt[2*CNT_W +: CNT_W], 0);
    cyc();
    sif.rx_valid = 1'b0; sif.rx_fix = '0;
    chk("fix_lane2_after_clr", fix_cnt[2*CNT_W +: CNT_W], 1);

    // Single-cycle lane-3 lock loss, then disable during RESET.
    sif.word_lock = 4'b0111; cyc(); sif.word_lock = '1;
    chk("lockdrop_retrain", state, M_RETRAIN);
    cyc();
    chk("lockdrop_reset", state, M_RESET);
    repeat (3) cyc();
    enable = 1'b0; cyc();
    chk("disable_idle", state, M_IDLE);
    chk("disable_serdes_rst", sif.serdes_rst, 1);

    // Lock never arrives: timeout retrain loop until the counter saturates.
    clr_stats = 1'b1; cyc(); clr_stats = 1'b0;
    sif.word_lock = '0; enable = 1'b1;
    n = 0;
    while (n < 300 && state !== 3'(M_RETRAIN)) begin cyc(); n++; end
    chk("timeout_cycle", n, 1 + HOLD + LOCK_TO);
    cyc();
    chk("retrain_cnt_first", retrain_cnt, 1);
    repeat (300 * (1 + HOLD + LOCK_TO)) cyc();
    chk("retrain_cnt_sat", retrain_cnt, 255);

    enable = 1'b0;
    repeat (3) cyc();
    model_on = 1'b0;
    repeat (3) cyc();
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

endmodule
